// File: rtl/run_monitor.sv
// run_monitor: watches the core's data bus for a store to the halt address,
// counts run/stall cycles until then, and afterwards streams a block of dmem
// words out through a valid/ready port.
module run_monitor #(
  parameter int          DATA_W     = 32,
  parameter int          AW         = 16,
  parameter int          DUMP_WORDS = 200,
  parameter logic [31:0] HALT_ADDR  = 32'h0000_7fff
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [DATA_W-1:0] daddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  output logic [AW-1:0]     dump_a,
  input  logic [DATA_W-1:0] dump_rd,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [DATA_W-1:0] dump_data,
  output logic [AW-1:0]     dump_idx,
  output logic              halt,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [31:0]       cycle_count,
  output logic [31:0]       stall_count
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_DUMP = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [DATA_W-1:0] HALT_CMP  = DATA_W'(HALT_ADDR);
  localparam logic [AW-1:0]     LAST_IDX  = AW'(DUMP_WORDS - 1);
  localparam logic [31:0]       CNT_MAX   = 32'hFFFF_FFFF;

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              halt_q, halt_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [31:0]       cycle_count_q, cycle_count_d;
  logic [31:0]       stall_count_q, stall_count_d;
  logic              trigger_s;
  logic              in_dump_s;

  // Halt trigger: a store whose full address matches the halt address.
  assign trigger_s = we && (daddr == HALT_CMP);
  assign in_dump_s = (state_q == ST_DUMP);

  // Next-state, counter, capture and dump-index logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    halt_d        = halt_q;
    done_d        = done_q;
    result_d      = result_q;
    cycle_count_d = cycle_count_q;
    stall_count_d = stall_count_q;
    case (state_q)
      ST_RUN: begin
        if (trigger_s) begin
          // The trigger cycle itself is not counted, even if stalled.
          result_d = wdata;
          halt_d   = 1'b1;
          idx_d    = {AW{1'b0}};
          state_d  = ST_DUMP;
        end else begin
          if (cycle_count_q != CNT_MAX) begin
            cycle_count_d = cycle_count_q + 32'd1;
          end else begin
            cycle_count_d = cycle_count_q;
          end
          if (stall && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + 32'd1;
          end else begin
            stall_count_d = stall_count_q;
          end
        end
      end
      ST_DUMP: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end else begin
          idx_d = idx_q;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        // Unreachable encoding: park the core frozen rather than resume it.
        halt_d  = 1'b1;
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RUN;
      idx_q         <= {AW{1'b0}};
      halt_q        <= 1'b0;
      done_q        <= 1'b0;
      result_q      <= {DATA_W{1'b0}};
      cycle_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      halt_q        <= halt_d;
      done_q        <= done_d;
      result_q      <= result_d;
      cycle_count_q <= cycle_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  // Dump port: decoded from the state register; read data passes straight through.
  assign dump_valid  = in_dump_s;
  assign dump_a      = in_dump_s ? idx_q : {AW{1'b0}};
  assign dump_idx    = in_dump_s ? idx_q : {AW{1'b0}};
  assign dump_data   = in_dump_s ? dump_rd : {DATA_W{1'b0}};

  assign halt        = halt_q;
  assign done        = done_q;
  assign result      = result_q;
  assign cycle_count = cycle_count_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_run_monitor.sv
// Randomized bench for run_monitor with a spec-level reference model.
module tb_run_monitor;

  localparam int          DW   = 4;
  localparam logic [31:0] HALT = 32'h0000_7fff;

  logic        clk = 1'b0;
  logic        rst, stall, we, dump_ready;
  logic [31:0] daddr, wdata, dump_rd, dump_data, result, cycle_count, stall_count;
  logic [15:0] dump_a, dump_idx;
  logic        dump_valid, halt, done;

  logic [31:0] mem [16];
  assign dump_rd = mem[dump_a[3:0]];

  int n_pass = 0;
  int n_total = 0;

  // Reference model: run mode 0, dump mode 1, finished mode 2.
  int          m_mode;
  int          m_idx;
  logic [31:0] m_cycles, m_stalls, m_result;

  run_monitor #(.DATA_W(32), .AW(16), .DUMP_WORDS(DW), .HALT_ADDR(HALT)) dut (
    .clk(clk), .rst(rst), .stall(stall), .daddr(daddr), .wdata(wdata), .we(we),
    .dump_a(dump_a), .dump_rd(dump_rd), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_data(dump_data), .dump_idx(dump_idx), .halt(halt), .done(done),
    .result(result), .cycle_count(cycle_count), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic m_reset();
    m_mode = 0; m_idx = 0; m_cycles = 32'd0; m_stalls = 32'd0; m_result = 32'd0;
  endtask

  // One clock edge; the model consumes the inputs that were stable before it.
  task automatic step();
    logic trig;
    trig = we && (daddr == HALT);
    @(posedge clk);
    if (m_mode == 0) begin
      if (trig) begin
        m_result = wdata; m_mode = 1; m_idx = 0;
      end else begin
        if (m_cycles != 32'hFFFF_FFFF) m_cycles = m_cycles + 32'd1;
        if (stall && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 32'd1;
      end
    end else if (m_mode == 1) begin
      if (dump_ready) begin
        if (m_idx == DW - 1) m_mode = 2;
        else m_idx = m_idx + 1;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; we = 1'b0; stall = 1'b0; dump_ready = 1'b0; daddr = 32'd0; wdata = 32'd0;
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] non_halt_addr();
    logic [31:0] a;
    a = $urandom;
    if (a == HALT) a = a ^ 32'h0000_0001;
    return a;
  endfunction

  task automatic do_trigger(input logic [31:0] val, input logic st);
    we = 1'b1; daddr = HALT; wdata = val; stall = st;
    step();
    we = 1'b0; stall = 1'b0; daddr = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b0; stall = 1'b0; dump_ready = 1'b0; daddr = 32'd0; wdata = 32'd0;
    #3;
    n_total++; if (halt !== 1'b0 || done !== 1'b0 || dump_valid !== 1'b0)
      $display("FAIL reset_flags: got halt=%b done=%b valid=%b exp 0 0 0", halt, done, dump_valid); else n_pass++;
    n_total++; if (cycle_count !== 32'd0 || stall_count !== 32'd0 || result !== 32'd0)
      $display("FAIL reset_regs: got cyc=%0d stl=%0d res=%h exp 0", cycle_count, stall_count, result); else n_pass++;
    n_total++; if (dump_idx !== 16'd0 || dump_a !== 16'd0)
      $display("FAIL reset_idx: got idx=%0d a=%0d exp 0", dump_idx, dump_a); else n_pass++;
  endtask

  task automatic test_count_and_trigger();
    logic [9:0] mask;
    int cnt;
    apply_reset();
    mask = 10'd0; cnt = 0;
    while (cnt < 3) begin
      int p;
      p = $urandom_range(9, 0);
      if (!mask[p]) begin mask[p] = 1'b1; cnt++; end
    end
    for (int i = 0; i < 10; i++) begin
      stall = mask[i]; we = 1'($urandom); daddr = non_halt_addr(); wdata = $urandom;
      step();
    end
    n_total++; if (cycle_count !== 32'd10 || stall_count !== 32'd3)
      $display("FAIL run_counts: got cyc=%0d stl=%0d exp 10 3", cycle_count, stall_count); else n_pass++;
    n_total++; if (halt !== 1'b0) $display("FAIL run_no_halt: got %b exp 0", halt); else n_pass++;
    do_trigger(32'hDEAD_BEEF, 1'b0);
    n_total++; if (halt !== 1'b1 || dump_valid !== 1'b1)
      $display("FAIL trig_latency: got halt=%b valid=%b exp 1 1", halt, dump_valid); else n_pass++;
    n_total++; if (result !== 32'hDEAD_BEEF || cycle_count !== 32'd10 || stall_count !== 32'd3)
      $display("FAIL trig_capture: got res=%h cyc=%0d stl=%0d exp deadbeef 10 3", result, cycle_count, stall_count); else n_pass++;
    dump_ready = 1'b1;
    for (int k = 0; k < DW; k++) begin
      n_total++; if (dump_valid !== 1'b1 || dump_idx !== 16'(k) || dump_data !== mem[k])
        $display("FAIL beat_%0d: got v=%b idx=%0d data=%0d exp 1 %0d %0d", k, dump_valid, dump_idx, dump_data, k, mem[k]); else n_pass++;
      n_total++; if (done !== 1'b0) $display("FAIL early_done_%0d: got %b exp 0", k, done); else n_pass++;
      step();
    end
    n_total++; if (done !== 1'b1 || dump_valid !== 1'b0 || halt !== 1'b1)
      $display("FAIL dump_done: got done=%b valid=%b halt=%b exp 1 0 1", done, dump_valid, halt); else n_pass++;
    step(); step();
    n_total++; if (done !== 1'b1 || dump_valid !== 1'b0 || dump_idx !== 16'd0 || result !== 32'hDEAD_BEEF)
      $display("FAIL done_hold: got done=%b valid=%b idx=%0d res=%h", done, dump_valid, dump_idx, result); else n_pass++;
  endtask

  task automatic test_non_trigger();
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      we = 1'b1; wdata = $urandom; stall = 1'($urandom);
      case (i % 3)
        0: daddr = 32'h0000_7ffe;
        1: daddr = 32'h0001_7fff;
        default: daddr = non_halt_addr();
      endcase
      step();
      n_total++; if (halt !== 1'b0 || cycle_count !== m_cycles || stall_count !== m_stalls)
        $display("FAIL near_miss_%0d: got halt=%b cyc=%0d stl=%0d exp 0 %0d %0d", i, halt, cycle_count, stall_count, m_cycles, m_stalls); else n_pass++;
    end
    we = 1'b0;
    n_total++; if (cycle_count !== 32'd20) $display("FAIL near_miss_total: got %0d exp 20", cycle_count); else n_pass++;
  endtask

  task automatic test_ready_toggle();
    logic [31:0] got [$];
    logic [31:0] prev_data;
    logic        prev_stalled;
    int          budget;
    apply_reset();
    for (int i = 0; i < 5; i++) begin stall = 1'($urandom); step(); end
    do_trigger($urandom, 1'b0);
    prev_stalled = 1'b0; prev_data = 32'd0; budget = 0;
    while (m_mode == 1 && budget < 40) begin
      case (budget)
        0, 3: dump_ready = 1'b1;
        1, 2: dump_ready = 1'b0;
        default: dump_ready = 1'($urandom);
      endcase
      n_total++; if (dump_valid !== 1'b1 || dump_idx !== 16'(m_idx) || dump_data !== mem[m_idx])
        $display("FAIL toggle_beat: got v=%b idx=%0d data=%0d exp 1 %0d %0d", dump_valid, dump_idx, dump_data, m_idx, mem[m_idx]); else n_pass++;
      if (prev_stalled) begin
        n_total++; if (dump_data !== prev_data)
          $display("FAIL toggle_stable: got %0d exp %0d", dump_data, prev_data); else n_pass++;
      end
      if (dump_ready) got.push_back(dump_data);
      prev_stalled = !dump_ready; prev_data = dump_data;
      step();
      budget++;
    end
    n_total++; if (m_mode != 2 || done !== 1'b1)
      $display("FAIL toggle_finish: got done=%b exp 1 within 40 cycles", done); else n_pass++;
    n_total++; if (got.size() != DW) $display("FAIL toggle_count: got %0d exp %0d", got.size(), DW); else n_pass++;
    for (int k = 0; k < DW && k < got.size(); k++) begin
      n_total++; if (got[k] !== mem[k]) $display("FAIL toggle_word_%0d: got %0d exp %0d", k, got[k], mem[k]); else n_pass++;
    end
    dump_ready = 1'b0;
  endtask

  task automatic test_reset_mid_dump();
    apply_reset();
    for (int i = 0; i < 5; i++) begin stall = 1'($urandom); step(); end
    stall = 1'b0;
    do_trigger($urandom, 1'b0);
    dump_ready = 1'b1; step(); step();
    n_total++; if (dump_idx !== 16'd2) $display("FAIL mid_idx: got %0d exp 2", dump_idx); else n_pass++;
    dump_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_total++; if (halt !== 1'b0 || done !== 1'b0 || dump_valid !== 1'b0 || dump_idx !== 16'd0)
      $display("FAIL async_abort: got halt=%b done=%b valid=%b idx=%0d exp 0", halt, done, dump_valid, dump_idx); else n_pass++;
    n_total++; if (cycle_count !== 32'd0 || stall_count !== 32'd0 || result !== 32'd0)
      $display("FAIL async_regs: got cyc=%0d stl=%0d res=%h exp 0", cycle_count, stall_count, result); else n_pass++;
    m_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin stall = 1'b1; step(); end
    stall = 1'b0;
    n_total++; if (cycle_count !== 32'd3 || stall_count !== 32'd3)
      $display("FAIL restart_counts: got cyc=%0d stl=%0d exp 3 3", cycle_count, stall_count); else n_pass++;
    do_trigger(32'h1234_5678, 1'b0);
    n_total++; if (dump_valid !== 1'b1 || dump_idx !== 16'd0 || dump_data !== mem[0])
      $display("FAIL fresh_dump: got v=%b idx=%0d data=%0d exp 1 0 %0d", dump_valid, dump_idx, dump_data, mem[0]); else n_pass++;
  endtask

  task automatic test_trigger_with_stall();
    logic [31:0] first;
    apply_reset();
    for (int i = 0; i < 4; i++) step();
    first = $urandom;
    do_trigger(first, 1'b1);
    n_total++; if (stall_count !== 32'd0 || cycle_count !== 32'd4 || result !== first)
      $display("FAIL stall_trigger: got stl=%0d cyc=%0d res=%h exp 0 4 %h", stall_count, cycle_count, result, first); else n_pass++;
    for (int i = 0; i < DW + 3; i++) begin
      we = 1'b1; daddr = HALT; wdata = ~first; stall = 1'b1; dump_ready = 1'b1;
      step();
      n_total++; if (result !== m_result || stall_count !== m_stalls || cycle_count !== m_cycles || halt !== 1'b1)
        $display("FAIL frozen_%0d: got res=%h stl=%0d cyc=%0d halt=%b exp %h %0d %0d 1", i, result, stall_count, cycle_count, halt, m_result, m_stalls, m_cycles); else n_pass++;
    end
    n_total++; if (done !== 1'b1 || result !== first)
      $display("FAIL frozen_end: got done=%b res=%h exp 1 %h", done, result, first); else n_pass++;
    we = 1'b0; stall = 1'b0; dump_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[0] = 32'd11; mem[1] = 32'd22; mem[2] = 32'd33; mem[3] = 32'd44;
    m_reset();
    test_reset();
    test_count_and_trigger();
    test_non_trigger();
    test_ready_toggle();
    test_reset_mid_dump();
    test_trigger_with_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
RUN_MONITOR -- requirements
Module: run_monitor

Interface
REQ-001: Parameter DATA_W, default 32, data and bus address width.
REQ-002: Parameter AW, default 16, dmem word-address width.
REQ-003: Parameter DUMP_WORDS, default 200, number of dmem words streamed after halt (1..2^AW).
REQ-004: Parameter HALT_ADDR, default 32'h0000_7fff, byte address whose write terminates the run.
REQ-005: clk  input  1  single clock; all state updates on rising edge.
REQ-006: rst  input  1  asynchronous, active-high reset.
REQ-007: stall  input  1  core pipeline stall indication for the current cycle.
REQ-008: daddr  input  DATA_W  core data-bus address (aluout).
REQ-009: wdata  input  DATA_W  core store data (writedata).
REQ-010: we  input  1  core store strobe (memwrite).
REQ-011: dump_a  output  AW  word address to dmem auxiliary read port.
REQ-012: dump_rd  input  DATA_W  dmem auxiliary read data, combinational from dump_a.
REQ-013: dump_valid  output  1  dump_data/dump_idx valid.
REQ-014: dump_ready  input  1  sink accepts the current dump word.
REQ-015: dump_data  output  DATA_W  dumped word.
REQ-016: dump_idx  output  AW  index of dumped word.
REQ-017: halt  output  1  run terminated; core must be frozen by integrator.
REQ-018: done  output  1  dump complete.
REQ-019: result  output  DATA_W  store data captured at halt.
REQ-020: cycle_count  output  32  cycles elapsed in RUN.
REQ-021: stall_count  output  32  RUN cycles with stall=1.

Function
REQ-022: FSM states RUN, DUMP, DONE; encoding free.
REQ-023: RUN: trigger = we & (daddr == HALT_ADDR), exact 32-bit compare; any other address, or we=0, is no trigger.
REQ-024: RUN, no trigger: cycle_count +1; stall_count +1 when stall=1; both saturate at 32'hFFFF_FFFF.
REQ-025: RUN, trigger cycle: counters do not increment (stall ignored); result <= wdata; next state DUMP; halt=1 from next cycle.
REQ-026: halt is registered, stays 1 in DUMP and DONE until rst.
REQ-027: DUMP: index register idx starts at 0; dump_a = idx, dump_idx = idx, dump_data = dump_rd (combinational pass-through), dump_valid = 1.
REQ-028: DUMP: transfer when dump_valid & dump_ready; idx +1 per transfer; idx held otherwise, outputs stable while dump_ready=0.
REQ-029: DUMP: transfer at idx = DUMP_WORDS-1 -> DONE next cycle; done=1 registered from then.
REQ-030: DONE: dump_valid=0; all outputs hold; only rst leaves DONE.
REQ-031: In DUMP and DONE, we/daddr/wdata/stall are ignored; counters and result frozen.
REQ-032: Outside DUMP: dump_valid=0, dump_a=0, dump_idx=0.
REQ-033: Latency: trigger edge -> halt=1 and dump_valid=1 both one cycle later; max dump throughput one word/cycle.

Reset
REQ-034: rst=1 asynchronously forces state RUN, idx=0, halt=0, done=0, result=0, cycle_count=0, stall_count=0, dump_valid=0.
REQ-035: rst asserted mid-DUMP aborts the dump; no partial-transfer state survives; after release counting restarts from 0 on first edge.
REQ-036: First rising edge with rst=0 counts as RUN cycle 1.

Verification
REQ-037: 10 RUN cycles, stall high on 3 of them, then we=1 daddr=32'h7fff wdata=32'hDEAD_BEEF -> cycle_count=10, stall_count=3, result=32'hDEADBEEF, halt=1 next cycle.
REQ-038: we=1 to daddr=32'h7ffe and 32'h0001_7fff -> no halt; counters keep incrementing.
REQ-039: DUMP_WORDS=4, dmem words 0..3 = 11,22,33,44, dump_ready=1 -> four consecutive beats idx 0..3 with those data, done=1 on cycle after last beat.
REQ-040: dump_ready toggled 1,0,0,1,... -> idx advances only on ready cycles, dump_data stable while stalled, no word skipped or repeated.
REQ-041: rst pulsed (asynchronous, between edges) during DUMP at idx=2 -> halt, done, dump_valid, counters read 0 immediately; second trigger later yields fresh dump from idx 0.
REQ-042: Trigger write with stall=1 in same cycle, plus further writes to HALT_ADDR in DUMP -> stall not counted, result keeps first wdata.
